// File: rtl/multicycle_processor_if.sv
// Shared instruction/data memory port of multicycle_processor.
//
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and
// holds all four stable until a cycle in which mem_ack is high. The access
// completes on the rising edge where mem_req && mem_ack. mem_ack may already
// be high in the first request cycle (zero-wait). mem_rdata is valid only
// alongside mem_ack on a read.
//
// Ports (by modport):
//   master : out mem_req, mem_we, mem_addr[AW], mem_wdata[DW]
//            in  mem_rdata[DW], mem_ack
//   slave  : mirror of master
interface multicycle_processor_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle 16-bit-ISA core. A six-state FSM controller (FETCH, DECODE,
// EXEC, MEM, WB, HALT) shares one req/ack memory port between instruction
// fetch and load/store.
//
// Parameters:
//   DW       datapath/register width (>= 16)
//   AW       memory word address / PC width (7..32, and AW <= DW)
//   RESET_PC PC value loaded on reset
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset
//   mem        multicycle_processor_if.master memory port
//   halted     core is in HALT
//   illegal    one-cycle pulse while an illegal opcode (0xA/0xE) executes
//   pc_out     current PC
//   cycle_cnt  non-halted cycles since reset (0 unless MP_PERF_CNT_EN)
//   instr_cnt  retired instructions (0 unless MP_PERF_CNT_EN)
//   fsm_state  controller state, for debug
//
// Build option: define MP_PERF_CNT_EN to include the performance counters.
module multicycle_processor #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_processor_if.master        mem,
  output logic                          halted,
  output logic                          illegal,
  output logic [AW-1:0]                 pc_out,
  output logic [31:0]                   cycle_cnt,
  output logic [31:0]                   instr_cnt,
  output logic [2:0]                    fsm_state
);

  localparam int SHW = $clog2(DW);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_INV  = 4'h4;
  localparam logic [3:0] OP_LSL  = 4'h5;
  localparam logic [3:0] OP_LSR  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_ILA  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_ILE  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] rf_q [8];
  logic [DW-1:0] rf_d [8];

  // Instruction fields
  logic [3:0]    op;
  logic [2:0]    rs1, rs2, rd;
  logic [DW-1:0] off_dw;
  logic [AW-1:0] off_aw;
  logic [AW-1:0] jmp_tgt;
  assign op     = ir_q[15:12];
  assign rs1    = ir_q[11:9];
  assign rs2    = ir_q[8:6];
  assign rd     = ir_q[5:3];
  assign off_dw = {{(DW-6){ir_q[5]}}, ir_q[5:0]};
  assign off_aw = {{(AW-6){ir_q[5]}}, ir_q[5:0]};

  // JMP target is inst[11:0] zero-extended (or truncated) to the PC width.
  if (AW > 12) begin : g_jmp_wide
    assign jmp_tgt = {{(AW-12){1'b0}}, ir_q[11:0]};
  end else if (AW == 12) begin : g_jmp_exact
    assign jmp_tgt = ir_q[11:0];
  end else begin : g_jmp_narrow
    assign jmp_tgt = ir_q[AW-1:0];
  end

  logic [AW-1:0] pc_inc, br_tgt;
  assign pc_inc = pc_q + AW'(1);
  assign br_tgt = pc_inc + off_aw;

  // Register reads: r0 is forced to zero.
  logic [DW-1:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 3'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 3'd0) ? '0 : rf_q[rs2];

  // ALU on the latched operands. Non-ALU opcodes fall through to the
  // load/store effective address A + off.
  logic [DW-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_INV:  alu_res = ~a_q;
      OP_LSL:  alu_res = a_q << b_q[SHW-1:0];
      OP_LSR:  alu_res = a_q >> b_q[SHW-1:0];
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = a_q + off_dw;
    endcase
  end

  // Raw (ungated) memory port drive from the FSM.
  logic          req_int, we_int;
  logic [AW-1:0] addr_int;
  logic [DW-1:0] wdata_int;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_d      = rf_q;
    req_int   = 1'b0;
    we_int    = 1'b0;
    addr_int  = '0;
    wdata_int = '0;
    case (state_q)
      S_FETCH: begin
        req_int  = 1'b1;
        addr_int = pc_q;
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata[15:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        state_d = (op == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: begin
            alu_d   = alu_res;
            state_d = S_MEM;
          end
          OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: begin
            alu_d   = alu_res;
            state_d = S_WB;
          end
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          OP_BNE: begin
            pc_d    = (a_q != b_q) ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = jmp_tgt;
            state_d = S_FETCH;
          end
          default: begin
            // Illegal opcodes retire as a NOP.
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        // Everything driven here comes from flops that do not change until
        // the ack edge, so the request stays stable through wait states.
        req_int   = 1'b1;
        we_int    = (op == OP_ST);
        addr_int  = alu_q[AW-1:0];
        wdata_int = (op == OP_ST) ? b_q : '0;
        if (mem.mem_ack) begin
          if (op == OP_ST) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (op == OP_LD) begin
          if (rs2 != 3'd0) rf_d[rs2] = mdr_q;
        end else begin
          if (rd != 3'd0) rf_d[rd] = alu_q;
        end
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rf_q    <= rf_d;
    end
  end

  // The FSM resets into FETCH, which would otherwise request; gating with
  // reset forces the port idle while reset is low and drops an in-flight
  // request the moment reset asserts.
  assign mem.mem_req   = reset & req_int;
  assign mem.mem_we    = reset & we_int;
  assign mem.mem_addr  = reset ? addr_int : '0;
  assign mem.mem_wdata = reset ? wdata_int : '0;

  assign halted    = (state_q == S_HALT);
  assign illegal   = (state_q == S_EXEC) && ((op == OP_ILA) || (op == OP_ILE));
  assign pc_out    = pc_q;
  assign fsm_state = state_q;

`ifdef MP_PERF_CNT_EN
  // Every instruction ends either by returning to FETCH (from EXEC, MEM
  // or WB) or by entering HALT from DECODE.
  logic        retire;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  assign retire = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                  ((state_d == S_HALT) && (state_q == S_DECODE));

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire)            instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: reset values, a load/add/store
// program, the ALU ops, r0, illegal opcode, branches, JMP, a stalled load,
// HALT, and reset during a stalled store.
module tb_multicycle_processor;
  localparam int            DW     = 16;
  localparam int            AW     = 16;
  localparam logic [AW-1:0] RST_PC = 16'h0010;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          halted, illegal;
  logic [AW-1:0] pc_out;
  logic [31:0]   cycle_cnt, instr_cnt;
  logic [2:0]    fsm_state;

  multicycle_processor_if #(.DW(DW), .AW(AW)) bus ();

  multicycle_processor #(.DW(DW), .AW(AW), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (bus),
    .halted    (halted),
    .illegal   (illegal),
    .pc_out    (pc_out),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt),
    .fsm_state (fsm_state)
  );

  // Memory model: addresses below 16 are data and take stall_n wait
  // cycles; code is always zero-wait. force_ack injects a stray ack.
  logic [15:0] mem_arr [0:255];
  int          stall_n   = 0;
  int          wait_ctr;
  logic        force_ack = 1'b0;
  logic        data_region;

  assign data_region   = (bus.mem_addr < 16'd16);
  assign bus.mem_ack   = force_ack | (bus.mem_req & (~data_region | (wait_ctr >= stall_n)));
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:0]];

  always @(posedge clk or negedge reset) begin
    if (!reset)                             wait_ctr <= 0;
    else if (bus.mem_req && bus.mem_ack)    wait_ctr <= 0;
    else if (bus.mem_req)                   wait_ctr <= wait_ctr + 1;
  end

  always @(posedge clk) begin
    if (reset && bus.mem_req && bus.mem_ack && bus.mem_we)
      mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
  end

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the core fetches from addr; n = clock edges taken.
  task automatic wait_fetch(input logic [AW-1:0] addr, output int n);
    n = 0;
    while (!(fsm_state == ST_FETCH && bus.mem_req && bus.mem_addr == addr) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("fetch_timeout", {16'd0, bus.mem_addr}, {16'd0, addr});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    mem_arr[0]  = 16'h7FFF;
    mem_arr[1]  = 16'h0002;
    mem_arr[3]  = 16'hFFFF;
    mem_arr[10] = 16'h1234;
    mem_arr[12] = 16'h5555;
    mem_arr[16'h10] = 16'h0040; // LD  r1,0(r0)
    mem_arr[16'h11] = 16'h0081; // LD  r2,1(r0)
    mem_arr[16'h12] = 16'h2298; // ADD r3,r1,r2
    mem_arr[16'h13] = 16'h10C2; // ST  r3,2(r0)
    mem_arr[16'h14] = 16'h32A0; // SUB r4,r1,r2
    mem_arr[16'h15] = 16'h54A8; // LSL r5,r2,r2
    mem_arr[16'h16] = 16'h9670; // SLT r6,r3,r1
    mem_arr[16'h17] = 16'h4238; // INV r7,r1
    mem_arr[16'h18] = 16'h1104; // ST  r4,4(r0)
    mem_arr[16'h19] = 16'h1145; // ST  r5,5(r0)
    mem_arr[16'h1A] = 16'h1186; // ST  r6,6(r0)
    mem_arr[16'h1B] = 16'h11C7; // ST  r7,7(r0)
    mem_arr[16'h1C] = 16'h26C0; // ADD r0,r3,r3
    mem_arr[16'h1D] = 16'h2008; // ADD r1,r0,r0
    mem_arr[16'h1E] = 16'h1043; // ST  r1,3(r0)
    mem_arr[16'h1F] = 16'h66A0; // LSR r4,r3,r2
    mem_arr[16'h20] = 16'h1108; // ST  r4,8(r0)
    mem_arr[16'h21] = 16'h77E8; // AND r5,r3,r7
    mem_arr[16'h22] = 16'h1149; // ST  r5,9(r0)
    mem_arr[16'h23] = 16'hA000; // illegal
    mem_arr[16'h24] = 16'hC005; // BNE r0,r0,+5
    mem_arr[16'h25] = 16'hB03F; // BEQ r0,r0,-1
    mem_arr[16'h30] = 16'h008A; // LD  r2,10(r0)
    mem_arr[16'h31] = 16'h108B; // ST  r2,11(r0)
    mem_arr[16'h32] = 16'hF000; // HALT

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",  {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_pc",    {16'd0, pc_out}, 32'h10);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instr", instr_cnt, 32'd0);
    chk("rst_state", {29'd0, fsm_state}, {29'd0, ST_FETCH});

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("first_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("first_we",   {31'd0, bus.mem_we}, 32'd0);
    chk("first_addr", {16'd0, bus.mem_addr}, 32'h10);
    chk("first_pc",   {16'd0, pc_out}, 32'h10);

    // LD, LD, ADD, ST with zero-wait memory
    wait_fetch(16'h14, n);
    chk("prog1_cycles", n, 32'd18);
    chk("m2_sum", {16'd0, mem_arr[2]}, 32'h8001);
`ifdef MP_PERF_CNT_EN
    chk("prog1_instr_cnt", instr_cnt, 32'd4);
    chk("prog1_cycle_cnt", cycle_cnt, 32'd18);
`else
    chk("prog1_instr_cnt", instr_cnt, 32'd0);
    chk("prog1_cycle_cnt", cycle_cnt, 32'd0);
`endif

    // ALU results and r0 behaviour
    wait_fetch(16'h23, n);
    chk("m3_r0_add", {16'd0, mem_arr[3]}, 32'h0000);
    chk("m4_sub",    {16'd0, mem_arr[4]}, 32'h7FFD);
    chk("m5_lsl",    {16'd0, mem_arr[5]}, 32'h0008);
    chk("m6_slt",    {16'd0, mem_arr[6]}, 32'h0001);
    chk("m7_inv",    {16'd0, mem_arr[7]}, 32'h8000);
    chk("m8_lsr",    {16'd0, mem_arr[8]}, 32'h2000);
    chk("m9_and",    {16'd0, mem_arr[9]}, 32'h8000);

    // Illegal opcode
    tick();
    chk("ill_decode", {31'd0, illegal}, 32'd0);
    tick();
    chk("ill_exec", {31'd0, illegal}, 32'd1);
    tick();
    chk("ill_after", {31'd0, illegal}, 32'd0);
    chk("ill_pc", {16'd0, pc_out}, 32'h24);

    // BNE not taken, BEQ self-loop
    wait_fetch(16'h25, n);
    chk("bne_cycles", n, 32'd3);
    repeat (3) tick();
    chk("beq_state", {29'd0, fsm_state}, {29'd0, ST_FETCH});
    chk("beq_addr", {16'd0, bus.mem_addr}, 32'h25);
    chk("beq_pc", {16'd0, pc_out}, 32'h25);
    tick();
    mem_arr[16'h25] = 16'hD030; // JMP 0x030 breaks the loop on next fetch
    tick();
    tick();
    chk("jmp_fetch_addr", {16'd0, bus.mem_addr}, 32'h25);
    wait_fetch(16'h30, n);
    chk("jmp_cycles", n, 32'd3);

    // LD with three wait cycles
    stall_n = 3;
    tick();
    tick();
    tick();
    chk("ld_req", {31'd0, bus.mem_req}, 32'd1);
    chk("ld_ack0", {31'd0, bus.mem_ack}, 32'd0);
    chk("ld_addr0", {16'd0, bus.mem_addr}, 32'h0A);
    chk("ld_we0", {31'd0, bus.mem_we}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ld_stall_req", {31'd0, bus.mem_req}, 32'd1);
      chk("ld_stall_ack", {31'd0, bus.mem_ack}, 32'd0);
      chk("ld_stall_addr", {16'd0, bus.mem_addr}, 32'h0A);
      chk("ld_stall_we", {31'd0, bus.mem_we}, 32'd0);
    end
    tick();
    chk("ld_ack", {31'd0, bus.mem_ack}, 32'd1);
    chk("ld_ack_addr", {16'd0, bus.mem_addr}, 32'h0A);
    tick();
    chk("ld_wb", {29'd0, fsm_state}, {29'd0, ST_WB});
    tick();
    chk("ld_wb_once", {29'd0, fsm_state}, {29'd0, ST_FETCH});
    chk("ld_next_addr", {16'd0, bus.mem_addr}, 32'h31);

    // Stalled ST, then HALT
    wait_fetch(16'h32, n);
    chk("st_stall_cycles", n, 32'd7);
    chk("m11_ld_st", {16'd0, mem_arr[11]}, 32'h1234);
    tick();
    tick();
    chk("halt_state", {29'd0, fsm_state}, {29'd0, ST_HALT});
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, bus.mem_req}, 32'd0);
    repeat (3) tick();
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_req_hold", {31'd0, bus.mem_req}, 32'd0);
    chk("halt_pc", {16'd0, pc_out}, 32'h32);
`ifdef MP_PERF_CNT_EN
    chk("halt_instr_cnt", instr_cnt, 32'd27);
    chk("halt_cycle_cnt", cycle_cnt, 32'd110);
`else
    chk("halt_instr_cnt", instr_cnt, 32'd0);
    chk("halt_cycle_cnt", cycle_cnt, 32'd0);
`endif

    // Reset during a stalled store
    mem_arr[16'h10] = 16'h100C; // ST r0,12(r0)
    stall_n = 5;
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst2_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rst2_addr", {16'd0, bus.mem_addr}, 32'h10);
    tick();
    tick();
    tick();
    chk("st_req", {31'd0, bus.mem_req}, 32'd1);
    chk("st_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_addr", {16'd0, bus.mem_addr}, 32'h0C);
    chk("st_ack", {31'd0, bus.mem_ack}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midrst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("midrst_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("midrst_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    chk("midrst_pc", {16'd0, pc_out}, 32'h10);
    chk("midrst_state", {29'd0, fsm_state}, {29'd0, ST_FETCH});
    chk("midrst_cycle", cycle_cnt, 32'd0);
    chk("midrst_instr", instr_cnt, 32'd0);
    force_ack = 1'b1;
    repeat (2) tick();
    chk("midrst_mem", {16'd0, mem_arr[12]}, 32'h5555);
    chk("midrst_req_hold", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    force_ack = 1'b0;
    #1;
    chk("rst3_req", {31'd0, bus.mem_req}, 32'd1);
    chk("rst3_addr", {16'd0, bus.mem_addr}, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_processor.md
# multicycle_processor

Parametrised multi-cycle successor to the single-cycle 16-bit core. It executes the same 4-bit-opcode, 16-bit-instruction ISA and uses an FSM controller in place of the combinational control unit. Instruction and data traffic share one memory port with a req/ack handshake. Data width, address width and reset vector are parameters, and the core adds a HALT state plus optional performance counters.

## Interface
- DW, 16: datapath and register width; must be ≥16.
- AW, 16: memory word-address and PC width.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable; valid while mem_req is high.
- mem_addr  out  AW  word address.
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  read data; valid with mem_ack. Instructions use bits [15:0].
- mem_ack  in  1  access complete; may be high in the same cycle as mem_req.
- halted  out  1  core is in HALT.
- illegal  out  1  one-cycle pulse on an illegal opcode.
- pc_out  out  AW  current PC, for debug.
- cycle_cnt  out  32  cycles since reset (see Configuration).
- instr_cnt  out  32  retired instructions (see Configuration).

## Operation
- Instruction fields: op[15:12], rs1[11:9], rs2[8:6], rd[5:3], off[5:0]. off is sign-extended to DW.
- Register file: 8×DW. r0 always reads 0, and writes to r0 are discarded.
- Opcodes:
  - 0 LD: rs2 ← M[rs1+off].
  - 1 ST: M[rs1+off] ← rs2.
  - 2 ADD, 3 SUB, 7 AND, 8 OR: rd ← rs1 op rs2.
  - 4 INV: rd ← ~rs1.
  - 5 LSL, 6 LSR: rd ← rs1 shifted by rs2[$clog2(DW)-1:0]; LSR is a logical shift.
  - 9 SLT: rd ← (signed rs1 < signed rs2) ? 1 : 0.
  - B BEQ / C BNE: if the condition holds, PC ← PC+1+off; otherwise PC+1.
  - D JMP: PC ← zero-extended inst[11:0].
  - F HALT.
  - A, E: illegal. Pulse `illegal`, then execute as a NOP.
- Arithmetic is modulo 2^DW. The memory address is the low AW bits of the sum. PC increments modulo 2^AW.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On the edge where mem_req&mem_ack, latch IR and go to DECODE.
  - DECODE: latch A=R[rs1] and B=R[rs2]. HALT opcode → HALT. Otherwise → EXEC.
  - EXEC: compute ALU result, branch decision or target.
    - Branch/JMP/illegal: update PC and go to FETCH.
    - LD/ST: go to MEM.
    - R-type: go to WB.
  - MEM: mem_req=1, mem_we=(op==ST), mem_addr=A+off, mem_wdata=B. Hold until ack.
    - LD: latch mem_rdata into MDR, then go to WB.
    - ST: PC ← PC+1, then go to FETCH.
  - WB: write ALU result or MDR to the register file, PC ← PC+1, go to FETCH.
  - HALT: terminal. mem_req=0, halted=1. Exit only via reset.
- mem_req, mem_we, mem_addr and mem_wdata must stay stable while mem_req is high and ack is low.

## Timing
- Latency with zero-wait memory (ack in the same cycle as req):
  - R-type: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/JMP: 3 cycles.
- Each wait cycle on ack adds one cycle.
- Instruction retire points (instr_cnt++):
  - WB exit.
  - ST MEM exit.
  - Branch/JMP/illegal EXEC exit.
  - HALT entry.
- While reset is low, all outputs take these values:
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - halted = 0, illegal = 0.
  - pc_out = RESET_PC.
  - both counters = 0.
  - State = FETCH; registers and IR = 0.
- Reset asserted mid-access drops mem_req asynchronously. An in-flight ST is abandoned, and any ack arriving during reset is ignored.
- The first request is issued in the first cycle after reset deasserts.

## Configuration
- MP_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle while not halted.
  - instr_cnt increments on each retire.
  - Both are 32-bit and wrap at 2^32.
- Not defined: both ports are tied to 0 and no counter logic is synthesised.

## Test plan
- Reset with RESET_PC=0x0010, then release → first FETCH has mem_addr=0x0010, mem_req=1, pc_out=0x0010.
- Program LD r1,0(r0); LD r2,1(r0); ADD r3,r1,r2; ST r3,2(r0), with M[0]=0x7FFF and M[1]=0x0002 → M[2]=0x8001. With zero-wait memory the sequence retires in 18 cycles.
- BEQ r0,r0,-1 → PC stays constant (self-loop). BNE r0,r0,+5 → PC+1.
- LD with mem_ack held low for 3 cycles → mem_addr and mem_we stable throughout; r2 is written exactly once.
- Write to r0, then ADD r1,r0,r0 → r1=0. Opcode 0xA → one-cycle `illegal` pulse and PC advances by 1. HALT → halted=1 and mem_req stays 0.
- Assert reset mid-ST (req high, ack low) → mem_req=0 on the same cycle and memory is unchanged. With MP_PERF_CNT_EN, both counters read 0.
